bram_fifo: RTL and testbench

Parametrised synchronous FIFO built on a simple-dual-port block RAM, with registered occupancy flags, programmable almost-full/almost-empty thresholds, a level count and one-cycle overflow/underflow error pulses. It is the general-purpose line/sample buffer between pipeline stages of the filter datapath, replacing hand-managed RAM addressing in each stage.

---
 rtl/bram_pkg.sv | 25 ++
 rtl/bram_fifo_if.sv | 37 +++
 rtl/bram_sdp.sv | 31 +++
 rtl/bram_fifo.sv | 111 +++++++++++
 tb/tb_bram_fifo.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bram_pkg.sv
// Shared helpers for the block-RAM FIFO: address sizing and parameter sanity.
package bram_pkg;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

    // Occupancy spans 0..DEPTH inclusive, so it needs one bit over the address.
    function automatic int level_width(input int addr_width);
        return addr_width + 1;
    endfunction

    function automatic bit is_pow2(input int value);
        return (value > 0) && ((value & (value - 1)) == 0);
    endfunction

endpackage

// File: rtl/bram_fifo_if.sv
// Write/read/status bundle between a producer-consumer pair and bram_fifo.
interface bram_fifo_if
    import bram_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 512
);
    localparam int ADDR_WIDTH = clog2(DEPTH);
    localparam int LW         = level_width(ADDR_WIDTH);

    logic                  clear;
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_valid;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic [LW-1:0]         level;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output clear, wr_en, wr_data, rd_en,
        input  rd_data, rd_valid, full, empty, almost_full,
        input  almost_empty, level, overflow, underflow
    );

    modport slave (
        input  clear, wr_en, wr_data, rd_en,
        output rd_data, rd_valid, full, empty, almost_full,
        output almost_empty, level, overflow, underflow
    );

endinterface

// File: rtl/bram_sdp.sv
// Simple-dual-port RAM: one write port, one read port with registered data.
module bram_sdp
    import bram_pkg::*;
#(
    parameter  int DATA_WIDTH = 16,
    parameter  int DEPTH      = 512,
    localparam int AW         = clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [AW-1:0]         raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // Only the output register resets; storage stays uninitialised.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)     rdata <= '0;
        else if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/bram_fifo.sv
// Synchronous FIFO over bram_sdp with registered flags, level and error pulses.
module bram_fifo
    import bram_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 512,
    parameter int AF_LEVEL   = DEPTH - 2,
    parameter int AE_LEVEL   = 2
) (
    input  logic          clk,
    input  logic          rst,
    bram_fifo_if.slave    bus
);

    localparam int AW = clog2(DEPTH);
    localparam int LW = level_width(AW);

    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [LW-1:0] LVL_ONE = LW'(1);
    localparam logic [LW-1:0] LVL_MAX = LW'(DEPTH);
    localparam logic [LW-1:0] LVL_AF  = LW'(AF_LEVEL);
    localparam logic [LW-1:0] LVL_AE  = LW'(AE_LEVEL);

    if (!is_pow2(DEPTH) || DEPTH < 4 || DATA_WIDTH < 1 ||
        AF_LEVEL > DEPTH || AE_LEVEL >= DEPTH) begin : g_bad_params
        $fatal(1, "bram_fifo: illegal parameter set");
    end

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] level_q;
    logic [LW-1:0] level_nxt;
    logic          full_q;
    logic          empty_q;
    logic          afull_q;
    logic          aempty_q;
    logic          rvalid_q;
    logic          ovf_q;
    logic          unf_q;
    logic          wr_ok;
    logic          rd_ok;

    // Acceptance uses registered flags; clear suppresses both ports.
    assign wr_ok = bus.wr_en && !full_q  && !bus.clear;
    assign rd_ok = bus.rd_en && !empty_q && !bus.clear;

    always_comb begin
        level_nxt = level_q;
        unique case (1'b1)
            bus.clear:      level_nxt = '0;
            wr_ok && !rd_ok: level_nxt = level_q + LVL_ONE;
            rd_ok && !wr_ok: level_nxt = level_q - LVL_ONE;
            default:        level_nxt = level_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
            rvalid_q <= 1'b0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            if (bus.clear) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (wr_ok) wr_ptr <= wr_ptr + PTR_ONE;
                if (rd_ok) rd_ptr <= rd_ptr + PTR_ONE;
            end
            level_q  <= level_nxt;
            full_q   <= (level_nxt == LVL_MAX);
            empty_q  <= (level_nxt == '0);
            afull_q  <= (level_nxt >= LVL_AF);
            aempty_q <= (level_nxt <= LVL_AE);
            rvalid_q <= rd_ok;
            ovf_q    <= bus.wr_en && full_q  && !bus.clear;
            unf_q    <= bus.rd_en && empty_q && !bus.clear;
        end
    end

    bram_sdp #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_ok),
        .waddr (wr_ptr),
        .wdata (bus.wr_data),
        .re    (rd_ok),
        .raddr (rd_ptr),
        .rdata (bus.rd_data)
    );

    assign bus.level        = level_q;
    assign bus.full         = full_q;
    assign bus.empty        = empty_q;
    assign bus.almost_full  = afull_q;
    assign bus.almost_empty = aempty_q;
    assign bus.rd_valid     = rvalid_q;
    assign bus.overflow     = ovf_q;
    assign bus.underflow    = unf_q;

endmodule

// File: tb/tb_bram_fifo.sv
// Directed bench for bram_fifo at DEPTH=8, DATA_WIDTH=16.
module tb_bram_fifo;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    bram_fifo_if #(.DATA_WIDTH(16), .DEPTH(8)) bus ();

    bram_fifo #(
        .DATA_WIDTH (16),
        .DEPTH      (8),
        .AF_LEVEL   (6),
        .AE_LEVEL   (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        bus.clear = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        bus.wr_data = '0;
        tick();
        tick();
        checks++;
        if ({bus.rd_data, bus.rd_valid, bus.full, bus.empty, bus.almost_full,
             bus.almost_empty, bus.level, bus.overflow, bus.underflow} !==
            {16'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state level=%0d empty=%b full=%b rd=%h want level=0 empty=1 full=0 rd=0",
                     bus.level, bus.empty, bus.full, bus.rd_data);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_fill();
        for (int i = 1; i <= 8; i++) begin
            bus.wr_en   = 1'b1;
            bus.wr_data = 16'(i);
            tick();
            checks++;
            if (bus.level !== 4'(i) || bus.almost_full !== (i >= 6) ||
                bus.full !== (i == 8) || bus.empty !== 1'b0 ||
                bus.almost_empty !== (i <= 2)) begin
                errors++;
                $display("FAIL fill_%0d level=%0d af=%b full=%b ae=%b want level=%0d af=%b full=%b",
                         i, bus.level, bus.almost_full, bus.full,
                         bus.almost_empty, i, i >= 6, i == 8);
            end
        end
        bus.wr_data = 16'hDEAD;
        tick();
        checks++;
        if (bus.overflow !== 1'b1 || bus.level !== 4'd8 || bus.full !== 1'b1) begin
            errors++;
            $display("FAIL overflow ovf=%b level=%0d want ovf=1 level=8",
                     bus.overflow, bus.level);
        end
        idle();
        tick();
        checks++;
        if (bus.overflow !== 1'b0 || bus.level !== 4'd8) begin
            errors++;
            $display("FAIL overflow_pulse ovf=%b level=%0d want ovf=0 level=8",
                     bus.overflow, bus.level);
        end
    endtask

    task automatic test_drain();
        for (int i = 1; i <= 8; i++) begin
            bus.rd_en = 1'b1;
            tick();
            checks++;
            if (bus.rd_valid !== 1'b1 || bus.rd_data !== 16'(i) ||
                bus.level !== 4'(8 - i) || bus.empty !== (i == 8) ||
                bus.full !== 1'b0) begin
                errors++;
                $display("FAIL drain_%0d rd=%h v=%b level=%0d want rd=%h v=1 level=%0d",
                         i, bus.rd_data, bus.rd_valid, bus.level, 16'(i), 8 - i);
            end
        end
        tick();
        checks++;
        if (bus.underflow !== 1'b1 || bus.rd_valid !== 1'b0 ||
            bus.rd_data !== 16'h0008 || bus.level !== 4'd0) begin
            errors++;
            $display("FAIL underflow unf=%b v=%b rd=%h want unf=1 v=0 rd=0008",
                     bus.underflow, bus.rd_valid, bus.rd_data);
        end
        idle();
        tick();
        checks++;
        if (bus.underflow !== 1'b0 || bus.empty !== 1'b1) begin
            errors++;
            $display("FAIL underflow_pulse unf=%b empty=%b want unf=0 empty=1",
                     bus.underflow, bus.empty);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 3; i++) begin
            bus.wr_en   = 1'b1;
            bus.wr_data = 16'(16'h0100 + i);
            tick();
        end
        bus.rd_en = 1'b1;
        for (int k = 0; k < 20; k++) begin
            bus.wr_data = 16'(16'h0103 + k);
            tick();
            checks++;
            if (bus.level !== 4'd3 || bus.rd_valid !== 1'b1 ||
                bus.rd_data !== 16'(16'h0100 + k) || bus.overflow || bus.underflow) begin
                errors++;
                $display("FAIL stream_%0d rd=%h level=%0d v=%b want rd=%h level=3 v=1",
                         k, bus.rd_data, bus.level, bus.rd_valid, 16'(16'h0100 + k));
            end
        end
        bus.wr_en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (bus.rd_data !== 16'(16'h0114 + k) || bus.level !== 4'(2 - k)) begin
                errors++;
                $display("FAIL stream_tail_%0d rd=%h level=%0d want rd=%h level=%0d",
                         k, bus.rd_data, bus.level, 16'(16'h0114 + k), 2 - k);
            end
        end
        idle();
        tick();
    endtask

    task automatic test_simultaneous();
        for (int i = 0; i < 8; i++) begin
            bus.wr_en   = 1'b1;
            bus.wr_data = 16'(16'h0200 + i);
            tick();
        end
        bus.rd_en   = 1'b1;
        bus.wr_data = 16'hBEEF;
        tick();
        checks++;
        if (bus.overflow !== 1'b1 || bus.underflow !== 1'b0 || bus.level !== 4'd7 ||
            bus.rd_data !== 16'h0200 || bus.full !== 1'b0) begin
            errors++;
            $display("FAIL full_wr_rd ovf=%b level=%0d rd=%h want ovf=1 level=7 rd=0200",
                     bus.overflow, bus.level, bus.rd_data);
        end
        bus.wr_en = 1'b0;
        for (int i = 1; i < 8; i++) tick();
        checks++;
        if (bus.empty !== 1'b1 || bus.rd_data !== 16'h0207) begin
            errors++;
            $display("FAIL full_drain empty=%b rd=%h want empty=1 rd=0207",
                     bus.empty, bus.rd_data);
        end
        bus.wr_en   = 1'b1;
        bus.rd_en   = 1'b1;
        bus.wr_data = 16'h0055;
        tick();
        checks++;
        if (bus.underflow !== 1'b1 || bus.overflow !== 1'b0 || bus.level !== 4'd1 ||
            bus.empty !== 1'b0 || bus.rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL empty_wr_rd unf=%b level=%0d v=%b want unf=1 level=1 v=0",
                     bus.underflow, bus.level, bus.rd_valid);
        end
        bus.wr_en = 1'b0;
        tick();
        checks++;
        if (bus.rd_data !== 16'h0055 || bus.rd_valid !== 1'b1 || bus.empty !== 1'b1) begin
            errors++;
            $display("FAIL empty_wr_rd_data rd=%h v=%b want rd=0055 v=1",
                     bus.rd_data, bus.rd_valid);
        end
        idle();
        tick();
    endtask

    task automatic test_clear();
        for (int i = 0; i < 5; i++) begin
            bus.wr_en   = 1'b1;
            bus.wr_data = 16'(16'h0300 + i);
            tick();
        end
        bus.rd_en = 1'b1;
        tick();
        bus.clear = 1'b1;
        tick();
        checks++;
        if (bus.level !== 4'd0 || bus.empty !== 1'b1 || bus.overflow !== 1'b0 ||
            bus.underflow !== 1'b0 || bus.rd_valid !== 1'b0 ||
            bus.almost_empty !== 1'b1 || bus.rd_data !== 16'h0300) begin
            errors++;
            $display("FAIL clear level=%0d empty=%b v=%b rd=%h want level=0 empty=1 v=0 rd=0300",
                     bus.level, bus.empty, bus.rd_valid, bus.rd_data);
        end
        idle();
        bus.wr_en   = 1'b1;
        bus.wr_data = 16'h00AA;
        tick();
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b1;
        tick();
        checks++;
        if (bus.rd_data !== 16'h00AA || bus.rd_valid !== 1'b1 || bus.empty !== 1'b1) begin
            errors++;
            $display("FAIL clear_reuse rd=%h v=%b want rd=00AA v=1",
                     bus.rd_data, bus.rd_valid);
        end
        idle();
        tick();
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 4; i++) begin
            bus.wr_en   = 1'b1;
            bus.wr_data = 16'(16'h0400 + i);
            tick();
        end
        bus.rd_en = 1'b1;
        tick();
        checks++;
        if (bus.level !== 4'd4 || bus.rd_data !== 16'h0400) begin
            errors++;
            $display("FAIL pre_reset level=%0d rd=%h want level=4 rd=0400",
                     bus.level, bus.rd_data);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.rd_data, bus.rd_valid, bus.full, bus.empty, bus.almost_full,
             bus.almost_empty, bus.level, bus.overflow, bus.underflow} !==
            {16'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL async_reset level=%0d empty=%b v=%b rd=%h want level=0 empty=1 v=0 rd=0",
                     bus.level, bus.empty, bus.rd_valid, bus.rd_data);
        end
        idle();
        tick();
        rst = 1'b0;
        tick();
        bus.wr_en   = 1'b1;
        bus.wr_data = 16'h0077;
        tick();
        bus.wr_en   = 1'b1;
        bus.wr_data = 16'h0078;
        bus.rd_en   = 1'b1;
        tick();
        checks++;
        if (bus.rd_data !== 16'h0077 || bus.level !== 4'd1) begin
            errors++;
            $display("FAIL post_reset rd=%h level=%0d want rd=0077 level=1",
                     bus.rd_data, bus.level);
        end
        bus.wr_en = 1'b0;
        tick();
        checks++;
        if (bus.rd_data !== 16'h0078 || bus.empty !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_2 rd=%h empty=%b want rd=0078 empty=1",
                     bus.rd_data, bus.empty);
        end
        idle();
        tick();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_fill();
        test_drain();
        test_back_to_back();
        test_simultaneous();
        test_clear();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
